bus_arbiter: RTL and testbench

Arbiter and sequencer for the shared 64-bit system bus (`address`, `data`, `read`, `write`) that connects the Processor, the GPU and later memory-mapped peripherals. Up to NREQ masters request single read or write transfers. The block grants one master at a time by round-robin, drives the bus strobes, and waits for the addressed slave's ready. It then returns the read data and a one-cycle acknowledge to the granted master.

---
 rtl/bus_arb_pkg.sv | 15 +
 rtl/bus_arbiter_rr_picker.sv | 34 +++
 rtl/bus_arbiter.sv | 173 +++++++++++++++++
 tb/tb_bus_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the system-bus arbiter.
package bus_arb_pkg;

    localparam int BUS_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        ACK  = 2'd2
    } state_t;

    // Read data returned when a transfer is abandoned by the watchdog.
    localparam logic [BUS_W-1:0] ERR_RDATA = '1;

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector; searches upward from ptr and wraps.
module rr_picker #(
    parameter int NREQ  = 2,
    parameter int IDX_W = 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  win_onehot,
    output logic [IDX_W-1:0] win_idx,
    output logic             any_req
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        win_onehot = '0;
        win_idx    = '0;
        found      = 1'b0;
        cand       = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % NREQ);
            if (!found && req[cand]) begin
                found            = 1'b1;
                win_idx          = cand;
                win_onehot[cand] = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter and sequencer for the shared 64-bit system bus.
// Define BUS_ARB_TIMEOUT_EN to add a watchdog that ends a stuck BUS phase with err.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NREQ = 2
`ifdef BUS_ARB_TIMEOUT_EN
    , parameter int TIMEOUT = 255
`endif
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      we,
    input  logic [NREQ*BUS_W-1:0] m_addr,
    input  logic [NREQ*BUS_W-1:0] m_wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      ack,
    output logic                 err,
    output logic [BUS_W-1:0]     rdata,
    output logic [BUS_W-1:0]     bus_addr,
    output logic [BUS_W-1:0]     bus_wdata,
    output logic                 bus_read,
    output logic                 bus_write,
    input  logic [BUS_W-1:0]     bus_rdata,
    input  logic                 bus_ready
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic [BUS_W-1:0] rdata_q, rdata_d;
    logic [BUS_W-1:0] addr_q, addr_d;
    logic [BUS_W-1:0] wdata_q, wdata_d;
    logic             read_q, read_d;
    logic             write_q, write_d;

    logic [NREQ-1:0]  pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             any_req;

    rr_picker #(
        .NREQ (NREQ),
        .IDX_W(IDX_W)
    ) u_picker (
        .req       (req),
        .ptr       (ptr_q),
        .win_onehot(pick_onehot),
        .win_idx   (pick_idx),
        .any_req   (any_req)
    );

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        read_d  = read_q;
        write_d = write_q;
`ifdef BUS_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = BUS;
                    idx_d   = pick_idx;
                    gnt_d   = pick_onehot;
                    addr_d  = m_addr[int'(pick_idx)*BUS_W +: BUS_W];
                    wdata_d = m_wdata[int'(pick_idx)*BUS_W +: BUS_W];
                    write_d = we[pick_idx];
                    read_d  = !we[pick_idx];
`ifdef BUS_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            BUS: begin
                // gnt stays up through ACK; only the strobes drop here.
                if (bus_ready) begin
                    state_d = ACK;
                    ack_d   = gnt_q;
                    rdata_d = write_q ? '0 : bus_rdata;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                end
`ifdef BUS_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    state_d = ACK;
                    ack_d   = gnt_q;
                    err_d   = 1'b1;
                    rdata_d = ERR_RDATA;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ACK: begin
                state_d = IDLE;
                gnt_d   = '0;
                ptr_d   = (idx_q == IDX_W'(NREQ - 1)) ? '0 : idx_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            read_q  <= read_d;
            write_q <= write_d;
`ifdef BUS_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_read  = read_q;
    assign bus_write = write_q;
`ifdef BUS_ARB_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: stimulus pushes expected acks, a monitor pops and compares them.
// Build with BUS_ARB_TIMEOUT_EN defined to exercise the watchdog path with TIMEOUT=4.
module tb_bus_arbiter;

    localparam int NREQ = 2;

    logic               clock = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req, we, gnt, ack;
    logic [NREQ*64-1:0] m_addr, m_wdata;
    logic               err, bus_read, bus_write, bus_ready;
    logic [63:0]        rdata, bus_addr, bus_wdata, bus_rdata;

    typedef struct {
        int          idx;
        logic [63:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   c;

`ifdef BUS_ARB_TIMEOUT_EN
    bus_arbiter #(.NREQ(NREQ), .TIMEOUT(4)) dut (
`else
    bus_arbiter #(.NREQ(NREQ)) dut (
`endif
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .we       (we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .gnt      (gnt),
        .ack      (ack),
        .err      (err),
        .rdata    (rdata),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_read (bus_read),
        .bus_write(bus_write),
        .bus_rdata(bus_rdata),
        .bus_ready(bus_ready)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int idx, input logic [63:0] rd, input logic e, input int at);
        exp_t x;
        x.idx = idx; x.rdata = rd; x.err = e; x.cyc = at;
        exp_q.push_back(x);
    endtask

    // Monitor: every ack pulse must match the oldest pending expectation.
    always @(negedge clock) begin
        if (!reset && ack != '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 64'(ack), 64'd0);
            end else begin
                exp_t x;
                logic [NREQ-1:0] one;
                x = exp_q.pop_front();
                one = '0;
                one[x.idx] = 1'b1;
                check("ack_onehot", 64'(ack), 64'(one));
                check("ack_gnt", 64'(gnt), 64'(one));
                check("ack_rdata", rdata, x.rdata);
                check("ack_err", 64'(err), 64'(x.err));
                check("ack_cycle", 64'(cyc), 64'(x.cyc));
                check("ack_strobes_low", {62'd0, bus_read, bus_write}, 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; req = '0; we = '0; m_addr = '0; m_wdata = '0;
        bus_rdata = '0; bus_ready = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_gnt_ack", {60'd0, gnt, ack}, 64'd0);
        check("rst_flags", {61'd0, err, bus_read, bus_write}, 64'd0);
        check("rst_rdata", rdata, 64'd0);
        check("rst_addr_wdata", bus_addr | bus_wdata, 64'd0);
        reset = 1'b0;
        @(negedge clock);

        // Single read by master 0, bus_ready in the 2nd BUS cycle.
        c = cyc;
        req = 2'b01; we = 2'b00; m_addr[63:0] = 64'h1000;
        push(0, 64'hDEAD_BEEF, 1'b0, c + 3);
        @(negedge clock);
        check("t1_read", 64'(bus_read), 64'd1);
        check("t1_write", 64'(bus_write), 64'd0);
        check("t1_addr1", bus_addr, 64'h1000);
        check("t1_gnt", 64'(gnt), 64'd1);
        @(negedge clock);
        check("t1_addr2", bus_addr, 64'h1000);
        bus_ready = 1'b1; bus_rdata = 64'hDEAD_BEEF;
        @(negedge clock);
        bus_ready = 1'b0; req = '0;
        @(negedge clock);

        // Single write by master 1; slave read data must not leak into rdata.
        c = cyc;
        req = 2'b10; we = 2'b10; m_addr[127:64] = 64'h2000; m_wdata[127:64] = 64'h55;
        push(1, 64'd0, 1'b0, c + 2);
        @(negedge clock);
        check("t2_write", 64'(bus_write), 64'd1);
        check("t2_read", 64'(bus_read), 64'd0);
        check("t2_wdata", bus_wdata, 64'h55);
        check("t2_addr", bus_addr, 64'h2000);
        check("t2_gnt", 64'(gnt), 64'd2);
        bus_ready = 1'b1; bus_rdata = 64'h1234;
        @(negedge clock);
        bus_ready = 1'b0; req = '0; we = '0;
        @(negedge clock);

        // Contention with bus_ready held high throughout: grants alternate 0,1,0,1.
        c = cyc;
        req = 2'b11; bus_ready = 1'b1; bus_rdata = 64'hA5A5;
        m_addr[63:0] = 64'h10; m_addr[127:64] = 64'h20;
        for (int i = 0; i < 4; i++) push(i % 2, 64'hA5A5, 1'b0, c + 2 + 3 * i);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("t3_bus_addr", bus_addr, (i % 2 == 0) ? 64'h10 : 64'h20);
            @(negedge clock);
            if (i == 3) begin
                req = '0; bus_ready = 1'b0;
            end
            @(negedge clock);
        end

        // Master 0 drops req during BUS; the transfer still completes.
        c = cyc;
        req = 2'b01; m_addr[63:0] = 64'h3000;
        push(0, 64'h77, 1'b0, c + 4);
        @(negedge clock);
        req = '0;
        check("t4_read", 64'(bus_read), 64'd1);
        @(negedge clock);
        @(negedge clock);
        bus_ready = 1'b1; bus_rdata = 64'h77;
        @(negedge clock);
        bus_ready = 1'b0;
        @(negedge clock);

        // Reset mid-BUS clears strobes and gnt at once and produces no ack.
        c = cyc;
        req = 2'b10; m_addr[127:64] = 64'h4000;
        @(negedge clock);
        check("t5_read_before", 64'(bus_read), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("t5_async_clear", {62'd0, bus_read, gnt[1] | gnt[0]}, 64'd0);
        req = '0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Pointer is back at 0 after reset: master 0 wins a tie.
        c = cyc;
        req = 2'b11; m_addr[63:0] = 64'h5000;
        push(0, 64'hB0B0, 1'b0, c + 2);
        @(negedge clock);
        check("t5_ptr_gnt", 64'(gnt), 64'd1);
        bus_ready = 1'b1; bus_rdata = 64'hB0B0;
        @(negedge clock);
        bus_ready = 1'b0; req = '0;
        @(negedge clock);

`ifdef BUS_ARB_TIMEOUT_EN
        // Watchdog expires after 4 BUS cycles without bus_ready.
        c = cyc;
        req = 2'b01;
        push(0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, c + 5);
        repeat (4) @(negedge clock);
        check("t6_read_at_limit", 64'(bus_read), 64'd1);
        @(negedge clock);
        req = '0;
        @(negedge clock);

        // bus_ready in the limit cycle wins over the watchdog.
        c = cyc;
        req = 2'b01;
        push(0, 64'hC3, 1'b0, c + 5);
        repeat (4) @(negedge clock);
        bus_ready = 1'b1; bus_rdata = 64'hC3;
        @(negedge clock);
        bus_ready = 1'b0; req = '0;
        @(negedge clock);
`else
        // Without the watchdog BUS waits as long as bus_ready stays low.
        c = cyc;
        req = 2'b01;
        repeat (105) @(negedge clock);
        check("t6_still_read", 64'(bus_read), 64'd1);
        check("t6_still_gnt", 64'(gnt), 64'd1);
        push(0, 64'hC3, 1'b0, c + 106);
        bus_ready = 1'b1; bus_rdata = 64'hC3;
        @(negedge clock);
        bus_ready = 1'b0; req = '0;
        @(negedge clock);
`endif

        repeat (2) @(negedge clock);
        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
